// File: rtl/universal_register_n_bit.sv
// N-bit universal register: parallel load plus a multi-step shift engine
// with a start/busy/done handshake. Define UNIVERSAL_REGISTER_ROTATE_EN to enable rotate-left (mode 11).
module universal_register_n_bit #(
    parameter int              WIDTH       = 8,
    parameter int              CNT_W       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_right,
    output logic             serial_out_left,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_SHL = 2'b10;
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
    localparam logic [1:0] MODE_ROL = 2'b11;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             modeEffective;

    // Modes that actually move data; anything else completes immediately.
    always_comb begin
        modeEffective = (mode == MODE_SHR) || (mode == MODE_SHL);
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
        if (mode == MODE_ROL) begin
            modeEffective = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d = data_in;
                end else if (start) begin
                    if ((shift_count != '0) && modeEffective) begin
                        mode_d  = mode;
                        rem_d   = shift_count;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                case (mode_q)
                    MODE_SHR: data_d = {serial_in_left, data_q[WIDTH-1:1]};
                    MODE_SHL: data_d = {data_q[WIDTH-2:0], serial_in_right};
`ifdef UNIVERSAL_REGISTER_ROTATE_EN
                    MODE_ROL: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
                    default:  data_d = data_q;
                endcase
                rem_d = rem_q - CNT_W'(1);
                // Last step: leave SHIFT and raise done as busy drops.
                if (rem_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= RESET_VALUE;
            rem_q   <= '0;
            mode_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign data_out         = data_q;
    assign serial_out_right = data_q[0];
    assign serial_out_left  = data_q[WIDTH-1];
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: doc/universal_register_n_bit.md
Name: universal_register_n_bit

Overview:
- N-bit parallel-in/parallel-out register; parametrised successor of the team's 1-bit load/latch register cell.
- Adds serial shift-left and shift-right modes, plus a multi-step shift engine with a start/busy/done handshake.
- Used as the general-purpose data holding and shifting element in datapaths and serialisers.
- Single clock domain.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of shift_count.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into data_out on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  parallel load request (IDLE only).
- data_in  input  WIDTH  parallel load data.
- mode  input  2  shift mode, latched on start: 00 none, 01 shift right, 10 shift left, 11 rotate left (optional).
- start  input  1  begin a multi-step shift (IDLE only).
- shift_count  input  CNT_W  number of shift steps, latched on start.
- serial_in_left  input  1  bit entering data_out[WIDTH-1] on shift right.
- serial_in_right  input  1  bit entering data_out[0] on shift left.
- data_out  output  WIDTH  register contents.
- serial_out_right  output  1  data_out[0], combinational from register.
- serial_out_left  output  1  data_out[WIDTH-1], combinational from register.
- busy  output  1  high while the shift engine is active.
- done  output  1  one-cycle pulse when an accepted start completes.

Behaviour:
- Reset (sync, active-high):
  - data_out = RESET_VALUE; busy = 0; done = 0; state = IDLE.
  - Applies mid-shift too: the operation is aborted and no done is pulsed.
- States: IDLE, SHIFT. All outputs registered except serial_out_*.
- IDLE priority, per edge:
  - load=1: data_out <= data_in. Any start in the same cycle is ignored.
  - Else start=1 with shift_count!=0 and an effective mode (01, 10, or 11 when enabled): latch mode and count into rem; busy <= 1; go to SHIFT. data_out is unchanged on this edge.
  - Else start=1 with shift_count==0 or a non-effective mode: stay IDLE; data_out unchanged; done <= 1 for one cycle.
  - Else: hold.
- SHIFT, one step per edge using the latched mode:
  - 01: data_out <= {serial_in_left, data_out[WIDTH-1:1]}.
  - 10: data_out <= {data_out[WIDTH-2:0], serial_in_right}.
  - 11: data_out <= {data_out[WIDTH-2:0], data_out[WIDTH-1]}.
  - rem decrements each step. On the step where rem==1: go to IDLE; busy <= 0; done <= 1 (one cycle).
  - serial_in_* are sampled live on each step, not latched.
- Latency: start accepted at edge k produces shifts at edges k+1 through k+N. busy is high after edge k until edge k+N. done is high for the cycle after edge k+N.
- load, start, mode, and shift_count are ignored while busy=1.
- shift_count > WIDTH is legal: shifting continues, filling with serial input (or rotating).
- done is never asserted together with busy.

Optional Feature:
- Macro: UNIVERSAL_REGISTER_ROTATE_EN.
- Defined: mode 11 is rotate left, as described in Behaviour.
- Undefined: mode 11 is non-effective. start with mode 11 gives no data change, busy stays 0, and done pulses one cycle later. No rotate logic is synthesised.

Test Plan:
- Reset then hold: reset=1 for 1 edge -> data_out=0x00, busy=0, done=0. With no inputs for 5 cycles, data_out stays 0x00.
- Load then shift right: load data_in=0xA5, then start mode=01 count=3 serial_in_left=1 -> busy high 3 cycles, data_out=0xF4, done pulses 1 cycle after the 3rd shift.
- Shift left: load 0x81, start mode=10 count=2 serial_in_right=0 -> data_out=0x04. load=1 with data_in=0xFF during busy -> ignored, final 0x04.
- Zero count / rotate:
  - start count=0 -> done next cycle, busy never high, data unchanged.
  - With ROTATE_EN, load 0x81, rotate count=3 -> 0x0C.
  - Without ROTATE_EN -> 0x81 unchanged, done after 1 cycle.
- Reset mid-operation: start mode=01 count=10, assert reset after the 4th shift -> data_out=0x00, busy=0, no done pulse.
- Simultaneous load+start in IDLE: load 0x3C, start count=2 -> data_out=0x3C, busy stays 0, no done.
